// File: rtl/adder_tree_s2p_packer.sv
// Serial-to-parallel packer feeding the adder tree.
// Block or sliding-window framing of signed samples into lanes.
module adder_tree_s2p_packer #(
    parameter  int DATA_I_WIDTH = 8,
    parameter  int DATA_NUM     = 5,
    parameter  int SLIDING      = 0,
    localparam int CNT_WIDTH    = $clog2(DATA_NUM + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             din_valid,
    input  logic [DATA_I_WIDTH-1:0]          din_data,
    output logic                             dout_valid,
    output logic [DATA_NUM*DATA_I_WIDTH-1:0] dout_data,
    output logic [CNT_WIDTH-1:0]             fill_cnt
);

    localparam int VW = DATA_NUM * DATA_I_WIDTH;
    localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DATA_NUM);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_NUM - 1);

    logic [VW-1:0]        shreg_q, shreg_d;
    logic [VW-1:0]        shifted;
    logic [VW-1:0]        dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic [CNT_WIDTH-1:0] fill_q, fill_d;

    // Newest sample always lands in lane 0; the oldest falls off the top.
    if (DATA_NUM == 1) begin : g_one
        assign shifted = din_data;
    end else begin : g_multi
        assign shifted = {shreg_q[VW-DATA_I_WIDTH-1:0], din_data};
    end

    always_comb begin
        shreg_d = shreg_q;
        fill_d  = fill_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        if (flush) begin
            shreg_d = '0;
            fill_d  = '0;
        end else if (din_valid) begin
            shreg_d = shifted;
            if (SLIDING != 0) begin
                if (fill_q != FULL) begin
                    fill_d = fill_q + 1'b1;
                end
                // Window is full once this sample arrives.
                if (fill_q >= LAST) begin
                    dout_d  = shifted;
                    valid_d = 1'b1;
                end
            end else begin
                if (fill_q == LAST) begin
                    fill_d  = '0;
                    dout_d  = shifted;
                    valid_d = 1'b1;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            fill_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            fill_q  <= fill_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign dout_valid = valid_q;
    assign dout_data  = dout_q;
    assign fill_cnt   = fill_q;

endmodule

// File: tb/tb_adder_tree_s2p_packer.sv
// Bench for adder_tree_s2p_packer: four configurations share one stimulus
// stream and are compared against a sample-list reference model.
module tb_adder_tree_s2p_packer;

    logic        clk = 1'b0;
    logic        rst, flush, din_valid;
    logic [15:0] din_data;

    logic        dv0, dv1, dv2, dv3;
    logic [63:0] dd0, dd1;
    logic [15:0] dd2, dd3;
    logic [2:0]  fc0, fc1;
    logic [0:0]  fc2, fc3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adder_tree_s2p_packer #(.DATA_I_WIDTH(16), .DATA_NUM(4), .SLIDING(0)) u_blk (
        .clk(clk), .rst(rst), .flush(flush), .din_valid(din_valid),
        .din_data(din_data), .dout_valid(dv0), .dout_data(dd0), .fill_cnt(fc0));
    adder_tree_s2p_packer #(.DATA_I_WIDTH(16), .DATA_NUM(4), .SLIDING(1)) u_sld (
        .clk(clk), .rst(rst), .flush(flush), .din_valid(din_valid),
        .din_data(din_data), .dout_valid(dv1), .dout_data(dd1), .fill_cnt(fc1));
    adder_tree_s2p_packer #(.DATA_I_WIDTH(16), .DATA_NUM(1), .SLIDING(0)) u_one (
        .clk(clk), .rst(rst), .flush(flush), .din_valid(din_valid),
        .din_data(din_data), .dout_valid(dv2), .dout_data(dd2), .fill_cnt(fc2));
    adder_tree_s2p_packer #(.DATA_I_WIDTH(16), .DATA_NUM(1), .SLIDING(1)) u_ones (
        .clk(clk), .rst(rst), .flush(flush), .din_valid(din_valid),
        .din_data(din_data), .dout_valid(dv3), .dout_data(dd3), .fill_cnt(fc3));

    // Reference: per configuration, the list of samples currently held
    // (oldest first) plus the last emitted vector.
    int          nn[4] = '{4, 4, 1, 1};
    bit          sl[4] = '{0, 1, 0, 1};
    logic [15:0] mem[4][4];
    int          cnt[4];
    logic        ev[4];
    logic [63:0] ed[4];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input int i);
        logic [63:0] p = '0;
        for (int k = 0; k < nn[i]; k++)
            p[k*16 +: 16] = mem[i][cnt[i]-1-k];
        return p;
    endfunction

    task automatic model(input int i, input bit r, input bit f, input bit v,
                         input logic [15:0] d);
        ev[i] = 1'b0;
        if (r) begin
            cnt[i] = 0;
            ed[i]  = '0;
        end else if (f) begin
            cnt[i] = 0;
        end else if (v) begin
            if (cnt[i] == nn[i]) begin
                for (int k = 0; k < nn[i] - 1; k++) mem[i][k] = mem[i][k+1];
                mem[i][nn[i]-1] = d;
            end else begin
                mem[i][cnt[i]] = d;
                cnt[i]++;
            end
            if (cnt[i] == nn[i]) begin
                ed[i] = pack(i);
                ev[i] = 1'b1;
                if (!sl[i]) cnt[i] = 0;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit f, input bit v,
                       input logic [15:0] d);
        logic        av[4];
        logic [63:0] ad[4];
        logic [63:0] af[4];
        rst = r; flush = f; din_valid = v; din_data = d;
        @(posedge clk);
        for (int i = 0; i < 4; i++) model(i, r, f, v, d);
        #1;
        av = '{dv0, dv1, dv2, dv3};
        ad = '{dd0, dd1, {48'b0, dd2}, {48'b0, dd3}};
        af = '{{61'b0, fc0}, {61'b0, fc1}, {63'b0, fc2}, {63'b0, fc3}};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("valid%0d", i), {63'b0, av[i]}, {63'b0, ev[i]});
            check($sformatf("data%0d", i), ad[i], ed[i]);
            check($sformatf("fill%0d", i), af[i], 64'(cnt[i]));
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0; ev[i] = 1'b0; ed[i] = '0;
        end
        #1;
        repeat (10) cyc(1, 0, 0, 16'd0);

        // 1,2,3,4 back-to-back, then let the pulse drop
        for (int s = 1; s <= 4; s++) cyc(0, 0, 1, 16'(s));
        check("blk_frame_const", dd0, 64'h0001_0002_0003_0004);
        check("blk_pulse_const", {63'b0, dv0}, 64'd1);
        cyc(0, 0, 0, 16'd0);
        check("blk_pulse_drop", {63'b0, dv0}, 64'd0);

        // 10..17 with din_valid toggling
        for (int s = 10; s <= 17; s++) begin
            cyc(0, 0, 1, 16'(s));
            cyc(0, 0, 0, 16'hdead);
        end
        check("blk_second_frame", dd0, 64'h000e_000f_0010_0011);

        // sliding-window view after a flush: 1..6
        cyc(0, 1, 0, 16'd0);
        for (int s = 1; s <= 6; s++) cyc(0, 0, 1, 16'(s));
        check("sld_last_window", dd1, 64'h0003_0004_0005_0006);

        // flush with a simultaneous sample drops it
        cyc(0, 1, 0, 16'd0);
        for (int s = 5; s <= 7; s++) cyc(0, 0, 1, 16'(s));
        cyc(0, 1, 1, 16'd99);
        check("flush_fill_zero", {61'b0, fc0}, 64'd0);
        for (int s = 1; s <= 4; s++) cyc(0, 0, 1, 16'(s));

        // reset mid-frame
        cyc(0, 0, 1, 16'd5);
        cyc(0, 0, 1, 16'd6);
        cyc(1, 0, 1, 16'd7);
        check("rst_data_zero", dd0, 64'd0);
        for (int s = 1; s <= 4; s++) cyc(0, 0, 1, 16'(s));

        // single-lane: -3 then 7
        cyc(0, 0, 1, 16'hfffd);
        check("one_neg", {48'b0, dd2}, 64'h0000_0000_0000_fffd);
        cyc(0, 0, 1, 16'h0007);
        check("one_pos", {48'b0, dd2}, 64'h0000_0000_0000_0007);

        // random traffic with occasional flush and reset
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 2) != 0,
                16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_tree_s2p_packer.md
Name: adder_tree_s2p_packer

Overview:
- Serial-to-parallel front end for the pipelined adder tree.
- Collects a stream of signed samples, one per valid cycle, into a packed DATA_NUM-lane vector.
- Emits each vector with a one-cycle valid pulse, directly compatible with the tree's din_valid/din_data input.
- Supports block mode (non-overlapping frames, e.g. decimating sum) and sliding mode (one output per sample after fill, e.g. moving sum).

Parameters:
- DATA_I_WIDTH, 8: width of one signed sample.
- DATA_NUM, 5: lanes per packed output vector; legal range >= 1.
- SLIDING, 0: 0 = block mode; 1 = sliding-window mode.
- CNT_WIDTH, $clog2(DATA_NUM+1): localparam, width of fill_cnt.

Ports:
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- flush  input  1  discard partial frame / window contents and restart filling.
- din_valid  input  1  qualifies din_data; no backpressure, accepted every asserted cycle.
- din_data  input  DATA_I_WIDTH  signed sample.
- dout_valid  output  1  one-cycle pulse, packed vector valid.
- dout_data  output  DATA_NUM*DATA_I_WIDTH  packed vector; lane k = bits [(k+1)*DATA_I_WIDTH-1 : k*DATA_I_WIDTH].
- fill_cnt  output  CNT_WIDTH  samples currently held toward the next output.

Behaviour:
- Lane order: lane 0 (LSBs) = most recent sample; lane DATA_NUM-1 = oldest.
- Storage: internal shift register shreg. On an accepted sample: shreg <= {shreg[lanes 0..N-2], din_data}, i.e. the new sample enters lane 0 and the others move up one lane.
- Reset (rst=1 at posedge): dout_valid=0, dout_data=0, fill_cnt=0, shreg=0. Reset mid-frame discards the partial frame. rst has priority over flush and din_valid.
- flush=1 (rst=0): fill_cnt <= 0 and shreg <= 0. dout_data holds its last value; dout_valid <= 0. A din_valid in the same cycle is dropped.
- Block mode (SLIDING=0):
  - On an accepted sample with fill_cnt < DATA_NUM-1: shift, fill_cnt++, dout_valid <= 0.
  - On an accepted sample with fill_cnt == DATA_NUM-1: dout_data <= packed shreg including the new sample; dout_valid <= 1; fill_cnt <= 0.
  - Latency: dout_valid is high in the cycle after the DATA_NUM-th sample is clocked in.
- Sliding mode (SLIDING=1):
  - fill_cnt saturates at DATA_NUM.
  - On an accepted sample: shift; fill_cnt <= min(fill_cnt+1, DATA_NUM).
  - If the new count equals DATA_NUM, dout_data <= updated window and dout_valid <= 1.
  - After the initial fill, every valid sample produces an output one cycle later.
- din_valid=0 and no flush: shreg and fill_cnt hold; dout_valid <= 0.
- dout_data is a separate output register. It changes only on an output event and is stable between pulses, even while the next frame is filling.
- Gaps of any length between valid samples are allowed. Back-to-back valid samples sustain one sample per clock with no bubbles.
- DATA_NUM=1: every accepted sample emits next cycle (both modes). fill_cnt is 0 in block mode and 1 after the first sample in sliding mode.
- No arithmetic and no width change: samples pass bit-exact.

Test Plan (DATA_I_WIDTH=16, DATA_NUM=4 unless stated):
- Block mode, rst 10 cycles, then samples 1,2,3,4 on consecutive cycles -> one cycle after sample 4: dout_valid=1 for exactly one cycle, dout_data={16'd1,16'd2,16'd3,16'd4} (lane0=4); fill_cnt sequence 1,2,3,0.
- Block mode, 8 samples 10..17 with din_valid toggling 1,0 -> two pulses, carrying {10,11,12,13} then {14,15,16,17}. dout_data holds {10,11,12,13} until the second pulse.
- Sliding mode, samples 1..6 back-to-back -> pulses after samples 4, 5 and 6, carrying {1,2,3,4}, {2,3,4,5}, {3,4,5,6}; fill_cnt stays at 4.
- Block mode, samples 5,6,7, then flush=1 together with din_valid=1 (sample 99), then samples 1,2,3,4 -> sample 99 is dropped; the only pulse carries {1,2,3,4}; fill_cnt=0 after flush.
- Block mode, samples 5,6, then rst for 1 cycle, then 1,2,3,4 -> all outputs 0 during reset; the only pulse carries {1,2,3,4}.
- DATA_NUM=1, samples -3 and 7 back-to-back -> two consecutive pulses with dout_data=16'hFFFD then 16'h0007.
